// File: rtl/sram_burst_reader.sv
// sram_burst_reader: single-clock operand SRAM with a write port and a burst-read
// engine. One request streams rd_len consecutive words from rd_base (wrapping at
// DEPTH) through a 2-entry output FIFO at up to one word per cycle.
// Optional feature macro: SRAM_PARITY_EN (stores an even-parity bit per word and
// raises a sticky par_err when a word entering the output FIFO fails the check).
//
// Handshake: a word transfers on every rising edge where rd_valid=1 and rd_ready=1.
// While rd_valid=1 and rd_ready=0, rd_valid/rd_data/rd_last hold their values.
module sram_burst_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int BUF_D  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_par_inv,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              rd_busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              par_err,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef SRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  mem_q;
  logic [MEM_W-1:0]  wr_word;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued_q;
  logic [ADDR_W-1:0] rd_addr;

  // mem_q holds a word in flight when infl_q=1; infl_last_q tags the final word
  logic              infl_q;
  logic              infl_last_q;

  logic [DATA_W-1:0] buf_data [2];
  logic              buf_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        buf_cnt;

  logic              accept;
  logic              issue;
  logic              issue_last;
  logic              pop;
  logic [2:0]        occ;

`ifdef SRAM_PARITY_EN
  assign wr_word = {(^wr_data) ^ wr_par_inv, wr_data};
`else
  logic unused_par_inv;
  assign wr_word        = wr_data;
  assign unused_par_inv = wr_par_inv;
`endif

  assign rd_addr   = base_q + issued_q[ADDR_W-1:0];
  assign rd_valid  = (buf_cnt != 2'd0);
  assign pop       = rd_valid & rd_ready;
  assign rd_data   = buf_data[rd_ptr];
  assign rd_last   = rd_valid & buf_last[rd_ptr];
  assign rd_busy   = (state != S_IDLE);
  assign dbg_state = state;

  // Array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // Array read port, 1-cycle latency; a same-cycle write to this address returns the old word
  always_ff @(posedge clk) begin
    if (issue) mem_q <= mem[rd_addr];
  end

  // Next-state and read-issue decision; a read is issued only if the FIFO can absorb it
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    occ        = {1'b0, buf_cnt} + {2'b0, infl_q} - {2'b0, pop};
    case (state)
      S_IDLE: begin
        if (rd_req && (rd_len != '0)) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (occ < 3'(BUF_D)) begin
          issue      = 1'b1;
          issue_last = ((issued_q + 1'b1) == len_q);
          if (issue_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // occ is the FIFO fill after this edge; zero means the last word just left
        if (occ == 3'd0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Burst control registers: state, latched request, issue counter, in-flight tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      infl_q      <= issue;
      infl_last_q <= issue_last;
      if (accept) begin
        base_q   <= rd_base;
        len_q    <= rd_len;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 1'b1;
      end
    end
  end

  // Output FIFO: every in-flight word is pushed; space was reserved when it was issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_cnt     <= 2'd0;
    end else begin
      if (infl_q) begin
        buf_data[wr_ptr] <= mem_q[DATA_W-1:0];
        buf_last[wr_ptr] <= infl_last_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_cnt <= buf_cnt + {1'b0, infl_q} - {1'b0, pop};
    end
  end

`ifdef SRAM_PARITY_EN
  logic par_err_q;
  assign par_err = par_err_q;

  // Sticky parity flag: cleared by an accepted request, set when a bad word enters the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (accept) begin
      par_err_q <= 1'b0;
    end else if (infl_q && (^mem_q)) begin
      par_err_q <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
